// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
// The initiator drives the request and m_ready; the responder drives the rest.
interface mem_responder_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output s_valid, addr, wen, wdata, wmask, m_ready,
    input  s_ready, m_valid, rdata, err
  );

  modport slave (
    input  s_valid, addr, wen, wdata, wmask, m_ready,
    output s_ready, m_valid, rdata, err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with fixed or LFSR-driven latency.
// Accesses outside the BASE window respond with err and leave memory untouched.
module mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LATENCY    = 0,
  parameter int          RAND_LAT   = 0,
  parameter logic [3:0]  LAT_MASK   = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int          CW    = (LATENCY < 16) ? 4 : $clog2(LATENCY + 1);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd1 << (DEPTH_LOG2 + 2));

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    m_valid_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [7:0]              lfsr_q;
  logic [31:0]             addr_q;
  logic                    wen_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wmask_q;

  logic [31:0]             mem_q [0:(1<<DEPTH_LOG2)-1];

  logic [7:0]              lfsr_d;
  logic [CW-1:0]           lat_d;
  logic [31:0]             off;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    oob;
  logic                    access;
  logic                    unused_off;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign lat_d  = (RAND_LAT != 0) ? CW'(lfsr_q[3:0] & LAT_MASK) : CW'(LATENCY);

  assign off        = addr_q - BASE;
  assign idx        = off[DEPTH_LOG2+1:2];
  assign oob        = ({1'b0, addr_q} < {1'b0, BASE}) || ({1'b0, addr_q} >= LIMIT);
  assign access     = (state_q == WAIT) && (cnt_q == '0);
  assign unused_off = ^{off[1:0], off[31:DEPTH_LOG2+2]};

  assign bus.s_ready = (state_q == IDLE);
  assign bus.m_valid = m_valid_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      lfsr_q    <= 8'hA5;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: if (bus.s_valid) begin
          addr_q  <= bus.addr;
          wen_q   <= bus.wen;
          wdata_q <= bus.wdata;
          wmask_q <= bus.wmask;
          cnt_q   <= lat_d;
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == '0) begin
          state_q   <= RESP;
          m_valid_q <= 1'b1;
          err_q     <= oob;
          rdata_q   <= (oob || wen_q) ? 32'h0 : mem_q[idx];
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RESP: if (bus.m_ready) begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never cleared; a reset landing on the access edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && access && wen_q && !oob) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: four instances (latency 0, 3, 5, random)
// checked against a word-array reference model and an LFSR latency predictor.
module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       sv = '0, mr = '0;
  logic [3:0]       sr, mv, er;
  logic [3:0][31:0] rd;
  logic [31:0]      addr = '0, wdata = '0;
  logic             wen = 1'b0;
  logic [3:0]       wmask = '0;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  logic [31:0] ref_mem [4][1024];
  bit          known   [4][1024];

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else     edges <= edges + 1;

  for (genvar k = 0; k < 4; k++) begin : g
    mem_responder_if bus();
    assign bus.s_valid = sv[k];
    assign bus.addr    = addr;
    assign bus.wen     = wen;
    assign bus.wdata   = wdata;
    assign bus.wmask   = wmask;
    assign bus.m_ready = mr[k];
    assign sr[k]       = bus.s_ready;
    assign mv[k]       = bus.m_valid;
    assign rd[k]       = bus.rdata;
    assign er[k]       = bus.err;

    mem_responder #(
      .DEPTH_LOG2 (10),
      .BASE       (BASE),
      .LATENCY    (k == 1 ? 3 : (k == 2 ? 5 : 0)),
      .RAND_LAT   (k == 3 ? 1 : 0),
      .LAT_MASK   (k == 3 ? 4'h7 : 4'hF)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  // One complete transaction on instance k; called at #1 after a rising edge.
  task automatic txn(input int k, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] m, input int hold);
    longint     la;
    bit         inr;
    int         idx, exp_lat, n;
    bit         rd_known;
    logic [31:0] exp_rd;
    logic [7:0]  ls;

    la  = longint'(a);
    inr = (la >= longint'(BASE)) && (la < longint'(BASE) + 4096);
    idx = int'(((la - longint'(BASE)) >> 2) & 1023);
    exp_rd   = 32'h0;
    rd_known = 1'b1;
    if (inr) begin
      if (w) begin
        if (m == 4'hF || known[k][idx]) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
          known[k][idx] = 1'b1;
        end
      end else begin
        rd_known = known[k][idx];
        exp_rd   = ref_mem[k][idx];
      end
    end
    case (k)
      0:       exp_lat = 1;
      1:       exp_lat = 4;
      2:       exp_lat = 6;
      default: begin ls = lfsr_at(edges); exp_lat = int'(ls[3:0] & 4'h7) + 1; end
    endcase

    chk("s_ready_idle", {31'b0, sr[k]}, 1);
    sv[k] = 1'b1; addr = a; wen = w; wdata = d; wmask = m;
    tick();
    sv[k] = 1'b0;
    addr = $urandom; wen = $urandom_range(0, 1); wdata = $urandom; wmask = 4'($urandom);
    n = 0;
    while (!mv[k] && n < 40) begin
      mr[k] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    mr[k] = 1'b0;
    chk("latency", n, exp_lat);
    if (k == 3) chk("lat_range", {31'b0, (n >= 1 && n <= 8)}, 1);
    chk("err", {31'b0, er[k]}, {31'b0, !inr});
    if (rd_known) chk("rdata", rd[k], exp_rd);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_m_valid", {31'b0, mv[k]}, 1);
      chk("hold_s_ready", {31'b0, sr[k]}, 0);
      chk("hold_err", {31'b0, er[k]}, {31'b0, !inr});
      if (rd_known) chk("hold_rdata", rd[k], exp_rd);
    end
    mr[k] = 1'b1;
    tick();
    mr[k] = 1'b0;
    chk("m_valid_drop", {31'b0, mv[k]}, 0);
    chk("s_ready_back", {31'b0, sr[k]}, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          seen;
    logic [31:0] a, oobs [4];
    oobs[0] = 32'h7FFF_FFFC; oobs[1] = 32'h8000_1000;
    oobs[2] = 32'h0000_0100; oobs[3] = 32'hFFFF_FFF0;

    // Reset state
    tick(); tick();
    chk("rst_m_valid", {28'b0, mv}, 0);
    chk("rst_err", {28'b0, er}, 0);
    for (int k = 0; k < 4; k++) chk("rst_rdata", rd[k], 0);
    rst = 1'b0;
    tick();
    chk("rst_s_ready", {28'b0, sr}, 32'hF);

    // Latency 0: full write then read back
    txn(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    txn(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0);

    // Latency 3: byte merge
    txn(1, 32'h8000_0040, 1'b1, 32'h1122_3344, 4'hF, 0);
    txn(1, 32'h8000_0040, 1'b1, 32'h0000_AB00, 4'b0010, 0);
    txn(1, 32'h8000_0042, 1'b0, 32'h0, 4'h0, 0);

    // Out-of-window accesses must not disturb memory (incl. aliasing index)
    txn(0, 32'h8000_0020, 1'b1, 32'hCAFE_F00D, 4'hF, 0);
    txn(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0);
    txn(0, 32'h8000_1000, 1'b0, 32'h0, 4'h0, 0);
    txn(0, 32'h8000_1020, 1'b1, 32'h0BAD_0BAD, 4'hF, 0);
    txn(0, 32'h7FFF_FFF0, 1'b1, 32'h0BAD_0BAD, 4'hF, 0);
    txn(0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 0);
    txn(0, 32'h8000_0FFC, 1'b1, 32'h1357_9BDF, 4'hF, 0);
    txn(0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 0);

    // Backpressure: response held for 5 cycles
    txn(1, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 5);

    // Reset one cycle into WAIT drops the pending write
    txn(2, 32'h8000_0080, 1'b1, 32'h55AA_55AA, 4'hF, 0);
    sv[2] = 1'b1; addr = 32'h8000_0080; wen = 1'b1; wdata = 32'h1234_5678; wmask = 4'hF;
    tick();
    sv[2] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_m_valid", {31'b0, mv[2]}, 0);
    tick(); tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mv[2]) seen = 1'b1;
    end
    chk("abort_no_resp", {31'b0, seen}, 0);
    chk("abort_s_ready", {31'b0, sr[2]}, 1);
    txn(2, 32'h8000_0080, 1'b0, 32'h0, 4'h0, 0);

    // Random latency instance: seed words, then mixed random traffic
    for (int i = 0; i < 16; i++)
      txn(3, BASE + 32'h100 + 32'(4*i), 1'b1, $urandom, 4'hF, 0);
    for (int t = 0; t < 100; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 7) == 0) a = oobs[$urandom_range(0, 3)];
      else a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      txn(3, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
